// File: rtl/l1_wb_cache.sv
// -----------------------------------------------------------------------------
// l1_wb_cache
//
// Direct-mapped, write-back, write-allocate L1 cache. It answers the pipeline's
// word interface (mem_*) and fetches or evicts whole 16-byte lines over a
// line-wide physical memory port (pmem_*). Hits complete in the request cycle.
// A miss first writes back a dirty victim, then fills, then returns to CHECK,
// where the still-held request hits.
//
// Parameters
//   INDEX_BITS       set-index width, NUM_SETS = 2**INDEX_BITS (16-byte lines)
//
// Ports
//   clk              clock
//   reset            synchronous, active-high
//   mem_address      byte address of the request (bit 0 ignored)
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp (wins over mem_read)
//   mem_byte_enable  write mask, [0] low byte, [1] high byte
//   mem_wdata        write data
//   mem_resp         one-cycle completion pulse
//   mem_rdata        read data, valid while mem_resp is high
//   pmem_address     line address, low four bits zero
//   pmem_read        line fill request, held until pmem_resp
//   pmem_write       line writeback request, held until pmem_resp
//   pmem_wdata       victim line, byte 0 in [7:0]
//   pmem_rdata       fill line, byte 0 in [7:0]
//   pmem_resp        physical memory completion pulse
// -----------------------------------------------------------------------------
module l1_wb_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic          mem_resp,
  output logic [15:0]   mem_rdata,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int NUM_SETS = 1 << INDEX_BITS;
  localparam int TAG_BITS = 12 - INDEX_BITS;

  localparam logic [1:0] CHECK     = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;

  // ---------------------------------------------------------------------------
  // Address decomposition
  // ---------------------------------------------------------------------------
  logic [2:0]            req_word;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  unused_addr_bit;

  assign req_word        = mem_address[3:1];
  assign req_index       = mem_address[3+INDEX_BITS:4];
  assign req_tag         = mem_address[15:4+INDEX_BITS];
  assign unused_addr_bit = mem_address[0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [NUM_SETS-1:0] valid_arr;
  logic [NUM_SETS-1:0] dirty_arr;
  logic [TAG_BITS-1:0] tag_arr  [NUM_SETS];
  logic [127:0]        data_arr [NUM_SETS];

  logic [1:0] state;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic          req_active;
  logic          hit;
  logic [127:0]  cur_line;
  logic [TAG_BITS-1:0] cur_tag;
  logic [127:0]  merged_line;

  assign req_active = mem_read | mem_write;
  assign cur_line   = data_arr[req_index];
  assign cur_tag    = tag_arr[req_index];
  assign hit        = valid_arr[req_index] && (cur_tag == req_tag);

  // Byte-merge of the write data into the addressed word of the current line.
  // Byte 2*word is the low byte, byte 2*word+1 the high byte.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    merged_line = cur_line;
    if (mem_byte_enable[0]) merged_line[{req_word, 4'd0} +: 8]      = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{req_word, 4'd0} + 8 +: 8]  = mem_wdata[15:8];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_address = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = 128'h0;

    case (state)
      CHECK: begin
        // Reset is gated in so a stale hit cannot acknowledge during reset.
        if (!reset && req_active && hit) begin
          mem_resp  = 1'b1;
          mem_rdata = cur_line[{req_word, 4'd0} +: 16];
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {cur_tag, req_index, 4'b0000};
        pmem_wdata   = cur_line;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, 4'b0000};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state and per-set status bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state     <= CHECK;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      case (state)
        CHECK: begin
          if (req_active) begin
            if (hit) begin
              if (mem_write && (mem_byte_enable != 2'b00))
                dirty_arr[req_index] <= 1'b1;
            end else if (valid_arr[req_index] && dirty_arr[req_index]) begin
              state <= WRITEBACK;
            end else begin
              state <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= FILL;
        end
        FILL: begin
          if (pmem_resp) begin
            valid_arr[req_index] <= 1'b1;
            dirty_arr[req_index] <= 1'b0;
            state                <= CHECK;
          end
        end
        default: state <= CHECK;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and data arrays
  // ---------------------------------------------------------------------------
  // NOTE: tag and data arrays are deliberately not reset; the cleared valid
  // bits make their contents irrelevant, and leaving them unreset lets them
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FILL && pmem_resp) begin
        data_arr[req_index] <= pmem_rdata;
        tag_arr[req_index]  <= req_tag;
      end else if (state == CHECK && mem_write && hit) begin
        data_arr[req_index] <= merged_line;
      end
    end
  end

endmodule

// File: tb/tb_l1_wb_cache.sv
// -----------------------------------------------------------------------------
// tb_l1_wb_cache
//
// Directed bench for l1_wb_cache. Inputs change on the falling edge and outputs
// are compared 1 ns later, well away from the rising edge. The physical memory
// side is played by hand in each step.
// -----------------------------------------------------------------------------
module tb_l1_wb_cache;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_byte_enable;
  logic [15:0]   mem_wdata;
  logic          mem_resp;
  logic [15:0]   mem_rdata;
  logic [15:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;

  int tests_run = 0;
  int tests_failed = 0;

  // Lines returned by memory, word 0 in [15:0].
  localparam logic [127:0] LINE_0040   = 128'h0000_0000_0000_0000_BEEF_0000_0000_A5A5;
  localparam logic [127:0] VICTIM_0040 = 128'h0000_0000_0000_0000_BE34_0000_0000_A5A5;
  localparam logic [127:0] LINE_0840   = 128'h0000_0000_0000_0000_CAFE_0000_0000_0000;
  localparam logic [127:0] LINE_1040   = 128'h0000_0000_0000_0000_0000_0000_0000_5A5A;

  l1_wb_cache #(.INDEX_BITS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: rising edge, then back to the falling edge where inputs change.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [1:0] be, input logic [15:0] wd);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
  endtask

  initial begin
    reset      = 1'b1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    req(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);

    // Reset
    cycle();
    cycle();
    #1;
    check("rst_mem_resp",   mem_resp,   1'b0);
    check("rst_pmem_read",  pmem_read,  1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1. Cold read miss at 0x0046, fill, then same-cycle hits
    req(1'b1, 1'b0, 16'h0046, 2'b00, 16'h0000);
    #1;
    check("t1_miss_no_resp", mem_resp, 1'b0);
    cycle();
    #1;
    check("t1_pmem_read",  pmem_read,    1'b1);
    check("t1_pmem_write", pmem_write,   1'b0);
    check("t1_pmem_addr",  pmem_address, 16'h0040);
    check("t1_no_resp_fill", mem_resp,   1'b0);
    pmem_rdata = LINE_0040;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t1_resp",      mem_resp,  1'b1);
    check("t1_rdata",     mem_rdata, 16'hBEEF);
    check("t1_read_drop", pmem_read, 1'b0);
    cycle();
    #1;
    check("t1_rehit_resp",  mem_resp,  1'b1);
    check("t1_rehit_rdata", mem_rdata, 16'hBEEF);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    #1;
    check("t1_word0", mem_rdata, 16'hA5A5);

    // 2. Write hit, low byte only, then read back
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0046, 2'b01, 16'h1234);
    #1;
    check("t2_wr_resp", mem_resp, 1'b1);
    cycle();
    req(1'b1, 1'b0, 16'h0046, 2'b00, 16'h0000);
    #1;
    check("t2_rd_resp",  mem_resp,  1'b1);
    check("t2_rd_rdata", mem_rdata, 16'hBE34);

    // 3. Dirty conflict miss at 0x0846: writeback, then fill
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0846, 2'b00, 16'h0000);
    #1;
    check("t3_miss_no_resp", mem_resp, 1'b0);
    cycle();
    #1;
    check("t3_wb_write", pmem_write,   1'b1);
    check("t3_wb_read",  pmem_read,    1'b0);
    check("t3_wb_addr",  pmem_address, 16'h0040);
    check("t3_wb_data",  pmem_wdata,   VICTIM_0040);
    cycle();
    #1;
    check("t3_wb_held", pmem_write, 1'b1);
    check("t3_wb_no_resp", mem_resp, 1'b0);
    pmem_resp = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t3_fill_write", pmem_write,   1'b0);
    check("t3_fill_read",  pmem_read,    1'b1);
    check("t3_fill_addr",  pmem_address, 16'h0840);
    check("t3_fill_no_resp", mem_resp,   1'b0);
    pmem_rdata = LINE_0840;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t3_resp",  mem_resp,  1'b1);
    check("t3_rdata", mem_rdata, 16'hCAFE);

    // 4. Clean conflict miss at 0x1040: fill only
    @(negedge clk);
    req(1'b1, 1'b0, 16'h1040, 2'b00, 16'h0000);
    cycle();
    #1;
    check("t4_no_wb",    pmem_write,   1'b0);
    check("t4_fill",     pmem_read,    1'b1);
    check("t4_addr",     pmem_address, 16'h1040);
    pmem_rdata = LINE_1040;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t4_resp",  mem_resp,  1'b1);
    check("t4_rdata", mem_rdata, 16'h5A5A);

    // 5. Reset during a fill with pmem_resp withheld
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0840, 2'b00, 16'h0000);
    cycle();
    #1;
    check("t5_fill",      pmem_read,    1'b1);
    check("t5_fill_addr", pmem_address, 16'h0840);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    #1;
    check("t5_read_drop", pmem_read,  1'b0);
    check("t5_no_write",  pmem_write, 1'b0);
    check("t5_no_resp",   mem_resp,   1'b0);
    @(negedge clk);
    reset = 1'b0;
    req(1'b1, 1'b0, 16'h1040, 2'b00, 16'h0000);
    #1;
    check("t5_invalid_miss", mem_resp, 1'b0);
    cycle();
    #1;
    check("t5_refill",      pmem_read,    1'b1);
    check("t5_refill_addr", pmem_address, 16'h1040);
    check("t5_clean_no_wb", pmem_write,   1'b0);
    pmem_rdata = LINE_1040;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t5_resp",  mem_resp,  1'b1);
    check("t5_rdata", mem_rdata, 16'h5A5A);

    // 6. Empty-mask write hit: acknowledged, no data change, line stays clean
    @(negedge clk);
    req(1'b0, 1'b1, 16'h1040, 2'b00, 16'hFFFF);
    #1;
    check("t6_wr_resp", mem_resp, 1'b1);
    cycle();
    req(1'b1, 1'b0, 16'h1040, 2'b00, 16'h0000);
    #1;
    check("t6_unchanged", mem_rdata, 16'h5A5A);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
    cycle();
    #1;
    check("t6_no_wb",   pmem_write,   1'b0);
    check("t6_fill",    pmem_read,    1'b1);
    check("t6_addr",    pmem_address, 16'h0040);
    pmem_rdata = LINE_0040;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    #1;
    check("t6_resp",  mem_resp,  1'b1);
    check("t6_rdata", mem_rdata, 16'hA5A5);

    // High-byte-only write into word 1 (initially 0x0000)
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0042, 2'b10, 16'hAB12);
    #1;
    check("hb_wr_resp", mem_resp, 1'b1);
    cycle();
    req(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000);
    #1;
    check("hb_rdata", mem_rdata, 16'hAB00);

    // Both read and write asserted behaves as a write
    @(negedge clk);
    req(1'b1, 1'b1, 16'h0042, 2'b11, 16'h7788);
    #1;
    check("rw_resp", mem_resp, 1'b1);
    cycle();
    req(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000);
    #1;
    check("rw_rdata", mem_rdata, 16'h7788);

    @(negedge clk);
    req(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    #1;
    check("idle_resp", mem_resp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
